// File: rtl/vblank_task_scheduler.sv
// Frame-level task sequencer: on the vertical-blank start line it requests each enabled
// game task in index order over a req/done handshake, and aborts anything still running
// at the deadline line.
module vblank_task_scheduler #(
   parameter int unsigned NUM_TASKS         = 3,
   parameter int unsigned VBLANK_START_LINE = 480,
   parameter int unsigned DEADLINE_LINE     = 524,
   parameter int unsigned FRAME_DIV         = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [9:0]           position_x_i,
   input  logic [9:0]           position_y_i,
   input  logic                 enable_i,
   input  logic [NUM_TASKS-1:0] task_en_i,
   input  logic [NUM_TASKS-1:0] task_done_i,
   output logic [NUM_TASKS-1:0] task_req_o,
   output logic                 tick_o,
   output logic                 busy_o,
   output logic [15:0]          frame_count_o,
   output logic                 overrun_o,
   input  logic                 overrun_clr_i
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [NUM_TASKS-1:0] OneT   = {{(NUM_TASKS-1){1'b0}}, 1'b1};
   localparam logic [7:0]           DivTop = 8'(FRAME_DIV - 1);

   logic [1:0]           state_q, state_d;
   logic [NUM_TASKS-1:0] req_q, req_d;
   logic                 tick_q, tick_d;
   logic [15:0]          frame_count_q, frame_count_d;
   logic                 overrun_q, overrun_d;
   logic [7:0]           div_cnt_q, div_cnt_d;

   logic                 start_ev;
   logic                 deadline_ev;
   logic                 dispatch;
   logic                 done_hit;
   logic [NUM_TASKS-1:0] first_pick;
   logic [NUM_TASKS-1:0] above_mask;
   logic [NUM_TASKS-1:0] next_cand;
   logic [NUM_TASKS-1:0] next_pick;

   assign start_ev    = (position_y_i == 10'(VBLANK_START_LINE)) && (position_x_i == 10'd0)
                        && enable_i;
   assign deadline_ev = (position_y_i == 10'(DEADLINE_LINE)) && (position_x_i == 10'd0);
   assign dispatch    = start_ev && (div_cnt_q == 8'd0) && (state_q == StIdle);
   assign done_hit    = |(task_done_i & req_q);

   // Lowest set bit via x & -x; above_mask keeps only indices strictly above the current one.
   assign first_pick = task_en_i & (~task_en_i + OneT);
   assign above_mask = ~((req_q << 1) - OneT);
   assign next_cand  = task_en_i & above_mask;
   assign next_pick  = next_cand & (~next_cand + OneT);

   always_comb begin
      if (start_ev) begin
         div_cnt_d = (div_cnt_q >= DivTop) ? 8'd0 : div_cnt_q + 8'd1;
      end else begin
         div_cnt_d = div_cnt_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      tick_d        = 1'b0;
      frame_count_d = frame_count_q;
      overrun_d     = overrun_q;
      if (overrun_clr_i) begin
         overrun_d = 1'b0;
      end
      case (state_q)
         StIdle: begin
            if (dispatch) begin
               tick_d        = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               if (|task_en_i) begin
                  req_d   = first_pick;
                  state_d = StRun;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            // Completing the last task wins over a coincident deadline.
            if (done_hit && !(|next_cand)) begin
               req_d   = '0;
               state_d = StDone;
            end else if (deadline_ev) begin
               req_d     = '0;
               state_d   = StIdle;
               overrun_d = 1'b1;
            end else if (done_hit) begin
               req_d = next_pick;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            req_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         req_q         <= '0;
         tick_q        <= 1'b0;
         frame_count_q <= 16'd0;
         overrun_q     <= 1'b0;
         div_cnt_q     <= 8'd0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         tick_q        <= tick_d;
         frame_count_q <= frame_count_d;
         overrun_q     <= overrun_d;
         div_cnt_q     <= div_cnt_d;
      end
   end

   assign task_req_o    = req_q;
   assign tick_o        = tick_q;
   assign busy_o        = (state_q == StRun);
   assign frame_count_o = frame_count_q;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_vblank_task_scheduler.sv
// Directed bench for vblank_task_scheduler: handshake ordering, skipping, frame divider,
// deadline abort and overrun flag, and reset mid-sequence.
module tb_vblank_task_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] x, y;
   logic       en;
   logic [2:0] task_en, task_done, task_req;
   logic       tick, busy, ovr, ovr_clr;
   logic [15:0] fc;

   logic       rst3;
   logic [9:0] y3;
   logic [2:0] req3;
   logic       tick3, busy3, ovr3;
   logic [15:0] fc3;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vblank_task_scheduler #(.NUM_TASKS(3), .VBLANK_START_LINE(480), .DEADLINE_LINE(524),
                           .FRAME_DIV(1)) dut (
      .clk_i(clk), .rst_i(rst), .position_x_i(x), .position_y_i(y), .enable_i(en),
      .task_en_i(task_en), .task_done_i(task_done), .task_req_o(task_req), .tick_o(tick),
      .busy_o(busy), .frame_count_o(fc), .overrun_o(ovr), .overrun_clr_i(ovr_clr)
   );

   vblank_task_scheduler #(.NUM_TASKS(3), .VBLANK_START_LINE(480), .DEADLINE_LINE(524),
                           .FRAME_DIV(3)) dut3 (
      .clk_i(clk), .rst_i(rst3), .position_x_i(10'd0), .position_y_i(y3), .enable_i(1'b1),
      .task_en_i(3'b000), .task_done_i(3'b000), .task_req_o(req3), .tick_o(tick3),
      .busy_o(busy3), .frame_count_o(fc3), .overrun_o(ovr3), .overrun_clr_i(1'b0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_event();
      y = 10'd480;
      x = 10'd0;
      step();
      y = 10'd10;
      x = 10'd5;
   endtask

   initial begin
      rst = 1'b1; rst3 = 1'b1; x = 10'd5; y = 10'd10; y3 = 10'd10; en = 1'b1;
      task_en = 3'b111; task_done = 3'b000; ovr_clr = 1'b0;
      step(); step();
      check("rst_req", 32'(task_req), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_fc", 32'(fc), 32'h0);
      check("rst_ovr", 32'(ovr), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      rst = 1'b0; rst3 = 1'b0;

      // All three tasks, each done in the second cycle of its request.
      start_event();
      check("t1_tick", 32'(tick), 32'h1);
      check("t1_busy", 32'(busy), 32'h1);
      check("t1_fc", 32'(fc), 32'h1);
      check("t1_req0a", 32'(task_req), 32'h1);
      step();
      check("t1_tick_pulse", 32'(tick), 32'h0);
      check("t1_req0b", 32'(task_req), 32'h1);
      task_done = 3'b001; step(); task_done = 3'b000;
      check("t1_req1a", 32'(task_req), 32'h2);
      step();
      check("t1_req1b", 32'(task_req), 32'h2);
      task_done = 3'b010; step(); task_done = 3'b000;
      check("t1_req2a", 32'(task_req), 32'h4);
      step();
      check("t1_req2b", 32'(task_req), 32'h4);
      task_done = 3'b100; step(); task_done = 3'b000;
      check("t1_req_end", 32'(task_req), 32'h0);
      check("t1_busy_end", 32'(busy), 32'h0);
      check("t1_fc_end", 32'(fc), 32'h1);
      check("t1_ovr", 32'(ovr), 32'h0);
      step();

      // Task 1 disabled, done returned in the first request cycle.
      task_en = 3'b101;
      start_event();
      check("t2_req0", 32'(task_req), 32'h1);
      task_done = 3'b001; step();
      check("t2_req2", 32'(task_req), 32'h4);
      task_done = 3'b100; step(); task_done = 3'b000;
      check("t2_end", 32'(task_req), 32'h0);
      check("t2_fc", 32'(fc), 32'h2);
      step();

      // enable_i low: start line is ignored.
      en = 1'b0;
      start_event();
      check("en_low_tick", 32'(tick), 32'h0);
      check("en_low_fc", 32'(fc), 32'h2);
      en = 1'b1;
      step();

      // Task 1 hangs until the deadline.
      task_en = 3'b111;
      start_event();
      task_done = 3'b001; step(); task_done = 3'b000;
      check("t4_req1", 32'(task_req), 32'h2);
      step(); step();
      check("t4_req1_held", 32'(task_req), 32'h2);
      task_done = 3'b001;  // non-requested done ignored
      step(); task_done = 3'b000;
      check("t4_ignore_done", 32'(task_req), 32'h2);
      y = 10'd524; x = 10'd0; step(); y = 10'd10; x = 10'd5;
      check("t4_abort_req", 32'(task_req), 32'h0);
      check("t4_abort_busy", 32'(busy), 32'h0);
      check("t4_ovr", 32'(ovr), 32'h1);
      check("t4_fc", 32'(fc), 32'h3);
      ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
      check("t4_clr", 32'(ovr), 32'h0);

      // Last done on the deadline cycle completes normally.
      task_en = 3'b001;
      start_event();
      task_done = 3'b001; y = 10'd524; x = 10'd0; step();
      task_done = 3'b000; y = 10'd10; x = 10'd5;
      check("t5_req", 32'(task_req), 32'h0);
      check("t5_ovr", 32'(ovr), 32'h0);
      check("t5_fc", 32'(fc), 32'h4);
      step();

      // Clear coincident with an abort: set wins.
      start_event();
      y = 10'd524; x = 10'd0; ovr_clr = 1'b1; step();
      y = 10'd10; x = 10'd5; ovr_clr = 1'b0;
      check("t5b_set_wins", 32'(ovr), 32'h1);
      ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
      check("t5b_clr", 32'(ovr), 32'h0);
      y = 10'd524; x = 10'd0; step(); y = 10'd10; x = 10'd5;
      check("idle_deadline", 32'(ovr), 32'h0);

      // Reset while task 1 is requested.
      task_en = 3'b111;
      start_event();
      task_done = 3'b001; step(); task_done = 3'b000;
      check("t6_req1", 32'(task_req), 32'h2);
      check("t6_fc_pre", 32'(fc), 32'h6);
      rst = 1'b1; step(); rst = 1'b0;
      check("t6_rst_req", 32'(task_req), 32'h0);
      check("t6_rst_busy", 32'(busy), 32'h0);
      check("t6_rst_fc", 32'(fc), 32'h0);
      check("t6_rst_ovr", 32'(ovr), 32'h0);
      start_event();
      check("t6_fc", 32'(fc), 32'h1);
      check("t6_req0", 32'(task_req), 32'h1);
      check("t6_tick", 32'(tick), 32'h1);

      // FRAME_DIV=3 instance: five events dispatch on the 1st and 4th only.
      for (int i = 0; i < 5; i++) begin
         y3 = 10'd480; step(); y3 = 10'd10;
         check($sformatf("div_tick%0d", i), 32'(tick3), (i == 0 || i == 3) ? 32'h1 : 32'h0);
         check($sformatf("div_req%0d", i), 32'(req3), 32'h0);
         step();
      end
      check("div_fc", 32'(fc3), 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
